// File: rtl/mem_stage_if.sv
// Byte-serial memory port between the memory-access stage and the memory controller.
interface mem_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_a_o;
  logic [7:0]        mem_dout_o;
  logic [7:0]        mem_din_i;
  logic              mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_a_o, mem_dout_o,
    input  mem_din_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_a_o, mem_dout_o,
    output mem_din_i, mem_ack_i
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: ALU results pass straight through; loads and stores
// run as byte-serial little-endian transfers while the pipeline is stalled.
module mem_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 8,
  parameter int unsigned SEL_W  = 3,
  // aluop encodings of the memory ops; override to match the core's op defines
  parameter logic [OP_W-1:0] OP_LB  = OP_W'('h40),
  parameter logic [OP_W-1:0] OP_LH  = OP_W'('h41),
  parameter logic [OP_W-1:0] OP_LW  = OP_W'('h42),
  parameter logic [OP_W-1:0] OP_LBU = OP_W'('h43),
  parameter logic [OP_W-1:0] OP_LHU = OP_W'('h44),
  parameter logic [OP_W-1:0] OP_SB  = OP_W'('h45),
  parameter logic [OP_W-1:0] OP_SH  = OP_W'('h46),
  parameter logic [OP_W-1:0] OP_SW  = OP_W'('h47)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              rd_enable_i,
  input  logic [OP_W-1:0]   aluop_i,
  input  logic [SEL_W-1:0]  alusel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [4:0]        rd_addr_o,
  output logic              rd_enable_o,
  output logic              stall_req_o,
  mem_stage_if.master       mem
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nx;
  logic [1:0]  idx;
  logic [1:0]  nbytes;
  logic [31:0] load_buf;

  logic        is_load, is_store, is_mem, sign_ext;
  logic [1:0]  nbytes_dec;
  logic [7:0]  store_byte;
  logic [DATA_W-1:0] load_ext;
  logic        unused_sel;

  assign unused_sel = ^alusel_i;
  assign is_mem     = is_load | is_store;

  // Decode op class and transfer size (count-1) from aluop
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    sign_ext   = 1'b0;
    nbytes_dec = 2'd0;
    case (aluop_i)
      OP_LB:  begin is_load  = 1'b1; sign_ext = 1'b1; end
      OP_LH:  begin is_load  = 1'b1; sign_ext = 1'b1; nbytes_dec = 2'd1; end
      OP_LW:  begin is_load  = 1'b1; nbytes_dec = 2'd3; end
      OP_LBU: begin is_load  = 1'b1; end
      OP_LHU: begin is_load  = 1'b1; nbytes_dec = 2'd1; end
      OP_SB:  begin is_store = 1'b1; end
      OP_SH:  begin is_store = 1'b1; nbytes_dec = 2'd1; end
      OP_SW:  begin is_store = 1'b1; nbytes_dec = 2'd3; end
      default: ;
    endcase
  end

  // Store byte select and load result extension
  always_comb begin
    case (idx)
      2'd0:    store_byte = rd_data_i[7:0];
      2'd1:    store_byte = rd_data_i[15:8];
      2'd2:    store_byte = rd_data_i[23:16];
      default: store_byte = rd_data_i[31:24];
    endcase
    case (nbytes_dec)
      2'd0:    load_ext = {{(DATA_W-8){sign_ext & load_buf[7]}}, load_buf[7:0]};
      2'd1:    load_ext = {{(DATA_W-16){sign_ext & load_buf[15]}}, load_buf[15:0]};
      default: load_ext = DATA_W'(load_buf);
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Byte index, size and load buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      nbytes   <= '0;
      load_buf <= '0;
    end else begin
      case (state)
        IDLE: if (is_mem) begin
          idx      <= '0;
          nbytes   <= nbytes_dec;
          load_buf <= '0;
        end
        ACCESS: if (mem.mem_ack_i) begin
          if (is_load) load_buf[{idx, 3'b000} +: 8] <= mem.mem_din_i;
          if (idx != nbytes) idx <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Next state and all outputs; everything is held at zero while reset is low
  always_comb begin
    state_nx       = state;
    rd_data_o      = '0;
    rd_addr_o      = '0;
    rd_enable_o    = 1'b0;
    stall_req_o    = 1'b0;
    mem.mem_req_o  = 1'b0;
    mem.mem_we_o   = 1'b0;
    mem.mem_a_o    = '0;
    mem.mem_dout_o = '0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          stall_req_o = 1'b1;
          state_nx    = ACCESS;
        end else begin
          rd_data_o   = rd_data_i;
          rd_addr_o   = rd_addr_i;
          rd_enable_o = rd_enable_i;
        end
      end
      ACCESS: begin
        stall_req_o    = 1'b1;
        mem.mem_req_o  = 1'b1;
        mem.mem_we_o   = is_store;
        mem.mem_a_o    = mem_addr_i + ADDR_W'(idx);
        mem.mem_dout_o = store_byte;
        if (mem.mem_ack_i && (idx == nbytes)) state_nx = DONE;
      end
      DONE: begin
        state_nx  = IDLE;
        rd_addr_o = rd_addr_i;
        if (is_load) begin
          rd_data_o   = load_ext;
          rd_enable_o = rd_enable_i;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!rst) begin
      rd_data_o      = '0;
      rd_addr_o      = '0;
      rd_enable_o    = 1'b0;
      stall_req_o    = 1'b0;
      mem.mem_req_o  = 1'b0;
      mem.mem_we_o   = 1'b0;
      mem.mem_a_o    = '0;
      mem.mem_dout_o = '0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues ops and queues the expected
// writeback and byte transfers; negedge monitors pop and compare.
module tb_mem_stage;

  localparam logic [7:0] NOP = 8'h00, ADD = 8'h01;
  localparam logic [7:0] LB = 8'h40, LH = 8'h41, LW = 8'h42, LBU = 8'h43;
  localparam logic [7:0] LHU = 8'h44, SB = 8'h45, SH = 8'h46, SW = 8'h47;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        en;
    bit          chk_data;
  } wb_t;

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [7:0]  d;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] rd_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        rd_enable_i = 1'b0;
  logic [7:0]  aluop_i = NOP;
  logic [2:0]  alusel_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_enable_o;
  logic        stall_req_o;
  logic        mem_ack = 1'b0;

  logic [7:0]  tb_mem  [256];
  logic [7:0]  ref_mem [256];
  wb_t         sbq[$];
  xfer_t       busq[$];
  int unsigned ack_delay = 0;
  int unsigned wait_cnt = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  bit          monitor_en = 1'b1;

  mem_stage_if #(.ADDR_W(32)) bus ();

  assign bus.mem_din_i = tb_mem[bus.mem_a_o[7:0]];
  assign bus.mem_ack_i = mem_ack;

  mem_stage #(.ADDR_W(32), .DATA_W(32), .OP_W(8), .SEL_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_data_i   (rd_data_i),
    .rd_addr_i   (rd_addr_i),
    .rd_enable_i (rd_enable_i),
    .aluop_i     (aluop_i),
    .alusel_i    (alusel_i),
    .mem_addr_i  (mem_addr_i),
    .rd_data_o   (rd_data_o),
    .rd_addr_o   (rd_addr_o),
    .rd_enable_o (rd_enable_o),
    .stall_req_o (stall_req_o),
    .mem         (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    tb_mem[a[7:0]]  = v;
    ref_mem[a[7:0]] = v;
  endtask

  // Memory controller: ack after ack_delay waiting cycles per byte, or tied high
  always @(posedge clk) begin
    #2;
    if (ack_delay == 0) mem_ack = 1'b1;
    else if (!bus.mem_req_o || mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else begin
      wait_cnt++;
      mem_ack = (wait_cnt >= ack_delay);
    end
  end

  // Monitor: byte transfers and writeback commits
  always @(negedge clk) begin
    if (rst && monitor_en) begin
      if (bus.mem_req_o) begin
        check("req_implies_stall", 32'(stall_req_o), 32'd1);
        check("req_no_wb_en", 32'(rd_enable_o), 32'd0);
        if (mem_ack) begin
          if (busq.size() == 0) note_fail("unexpected_xfer");
          else begin
            xfer_t x;
            x = busq.pop_front();
            check("xfer_addr", bus.mem_a_o, x.a);
            check("xfer_we", 32'(bus.mem_we_o), 32'(x.we));
            if (x.we) check("xfer_wdata", 32'(bus.mem_dout_o), 32'(x.d));
          end
          if (bus.mem_we_o) tb_mem[bus.mem_a_o[7:0]] = bus.mem_dout_o;
        end
      end
      if (!stall_req_o) begin
        if (sbq.size() == 0) note_fail("unexpected_commit");
        else begin
          wb_t e;
          e = sbq.pop_front();
          check("wb_en", 32'(rd_enable_o), 32'(e.en));
          check("commit_no_req", 32'(bus.mem_req_o), 32'd0);
          if (e.chk_data) begin
            check("wb_data", rd_data_o, e.data);
            check("wb_addr", 32'(rd_addr_o), 32'(e.addr));
          end
        end
      end
    end
  end

  // Compute expectations from the reference memory and drive the op
  task automatic issue_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, input logic en, input int unsigned dly,
                          output int unsigned nb);
    bit ld, st, sx;
    logic [31:0] w;
    wb_t e;
    xfer_t x;
    ld = 0; st = 0; sx = 0; nb = 0;
    case (op)
      LB:  begin ld = 1; sx = 1; nb = 1; end
      LH:  begin ld = 1; sx = 1; nb = 2; end
      LW:  begin ld = 1; nb = 4; end
      LBU: begin ld = 1; nb = 1; end
      LHU: begin ld = 1; nb = 2; end
      SB:  begin st = 1; nb = 1; end
      SH:  begin st = 1; nb = 2; end
      SW:  begin st = 1; nb = 4; end
      default: ;
    endcase
    e.addr = rd;
    e.chk_data = 1'b1;
    if (ld) begin
      w = 0;
      for (int unsigned i = 0; i < nb; i++) w = w | (32'(ref_mem[8'(addr + i)]) << (8 * i));
      if (sx && nb == 1 && w >= 32'd128)   w = w - 32'd256;
      if (sx && nb == 2 && w >= 32'd32768) w = w - 32'd65536;
      e.data = w;
      e.en   = en;
    end else if (st) begin
      e.data = 0;
      e.en   = 1'b0;
      e.chk_data = 1'b0;
      for (int unsigned i = 0; i < nb; i++) ref_mem[8'(addr + i)] = 8'(data >> (8 * i));
    end else begin
      e.data = data;
      e.en   = en;
    end
    for (int unsigned i = 0; i < nb; i++) begin
      x.a  = addr + i;
      x.we = st;
      x.d  = 8'(data >> (8 * i));
      busq.push_back(x);
    end
    sbq.push_back(e);
    ack_delay   = dly;
    aluop_i     = op;
    mem_addr_i  = addr;
    rd_data_i   = data;
    rd_addr_i   = rd;
    rd_enable_i = en;
    alusel_i    = 3'($urandom_range(7));
  endtask

  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd, input logic en, input int unsigned dly);
    int unsigned nb, stalls;
    bit done;
    issue_op(op, addr, data, rd, en, dly, nb);
    stalls = 0;
    done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (!stall_req_o) done = 1;
      else stalls++;
    end
    if (!done) note_fail("commit_timeout");
    if (dly == 0) check("stall_cycles", stalls, (nb == 0) ? 32'd0 : nb + 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nb;
    logic [7:0] ops [10];
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, ADD, NOP};
    for (int i = 0; i < 256; i++) poke(i, 8'($urandom));

    // Outputs forced to zero under reset even with a live ALU op
    aluop_i = ADD; rd_data_i = 32'hDEADBEEF; rd_addr_i = 5'd9; rd_enable_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_data", rd_data_o, 32'h0);
    check("rst_rd_addr", 32'(rd_addr_o), 32'h0);
    check("rst_rd_en", 32'(rd_enable_o), 32'h0);
    check("rst_stall", 32'(stall_req_o), 32'h0);
    check("rst_req", 32'(bus.mem_req_o), 32'h0);
    check("rst_we", 32'(bus.mem_we_o), 32'h0);
    check("rst_a", bus.mem_a_o, 32'h0);
    check("rst_dout", 32'(bus.mem_dout_o), 32'h0);
    rst = 1'b1;

    run_op(ADD, 32'h0, 32'h12345678, 5'd5, 1'b1, 0);
    poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
    run_op(LW, 32'h100, 32'h0, 5'd3, 1'b1, 0);
    poke(32'h7, 8'h80);
    run_op(LB, 32'h7, 32'h0, 5'd4, 1'b1, 0);
    run_op(LBU, 32'h7, 32'h0, 5'd4, 1'b1, 0);
    poke(32'h20, 8'h00); poke(32'h21, 8'h90);
    run_op(LH, 32'h20, 32'h0, 5'd6, 1'b1, 1);
    run_op(SH, 32'hFFFFFFFF, 32'hAABBCCDD, 5'd7, 1'b1, 2);
    run_op(LHU, 32'hFFFFFFFF, 32'h0, 5'd8, 1'b1, 0);
    run_op(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 0);

    // Reset mid-LW after two bytes; the retry must start again at byte 0
    issue_op(LW, 32'h40, 32'h0, 5'd10, 1'b1, 0, nb);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_req", 32'(bus.mem_req_o), 32'h0);
    check("midrst_stall", 32'(stall_req_o), 32'h0);
    check("midrst_rd_en", 32'(rd_enable_o), 32'h0);
    check("midrst_left_xfers", busq.size(), 32'd2);
    busq.delete();
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_op(LW, 32'h40, 32'h0, 5'd10, 1'b1, 0);
    run_op(ADD, 32'h0, 32'h0BADF00D, 5'd31, 1'b1, 0);

    // Store then load of the same word, back to back
    run_op(SW, 32'h80, 32'hCAFEF00D, 5'd1, 1'b1, 0);
    run_op(LW, 32'h80, 32'h0, 5'd2, 1'b1, 0);

    for (int k = 0; k < 80; k++) begin
      logic [7:0] op;
      op = ops[$urandom_range(9)];
      run_op(op, $urandom, $urandom, 5'($urandom), (op == NOP) ? 1'b0 : 1'($urandom),
             $urandom_range(2));
    end

    aluop_i = NOP;
    rd_enable_i = 1'b0;
    monitor_en = 1'b0;
    check("sb_drained", sbq.size(), 32'd0);
    check("xfers_drained", busq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline. It consumes the ex_mem pipeline register outputs and produces the writeback triple for mem_wb.
- Non-memory ops pass straight through, combinationally.
- Loads and stores run as byte-serial transfers over a req/ack port to the memory controller. The stage holds the pipeline through stall_req_o until the access completes.

Parameters:
- ADDR_W, 32, address width (mem_addr_i, mem_a_o)
- DATA_W, 32, register data width
- OP_W, 8, aluop width; must equal `AluOPlen
- SEL_W, 3, alusel width; must equal `AluSellen

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- rd_data_i  in  DATA_W  ALU result, or store data (rs2) for stores
- rd_addr_i  in  5  destination register
- rd_enable_i  in  1  writeback enable from ex_mem
- aluop_i  in  OP_W  operation; `LB/`LH/`LW/`LBU/`LHU/`SB/`SH/`SW are memory ops
- alusel_i  in  SEL_W  op class, unused except for passthrough decode
- mem_addr_i  in  ADDR_W  effective address
- rd_data_o  out  DATA_W  writeback data
- rd_addr_o  out  5  writeback register
- rd_enable_o  out  1  writeback enable
- stall_req_o  out  1  to stall controller; drives stall[4] and below
- mem_req_o  out  1  byte access request
- mem_we_o  out  1  1 = write
- mem_a_o  out  ADDR_W  byte address
- mem_dout_o  out  8  write byte
- mem_din_i  in  8  read byte, valid with mem_ack_i
- mem_ack_i  in  1  byte complete

Behaviour:
- FSM states: IDLE, ACCESS, DONE. Registers:
  - idx (2 bits)
  - nbytes (2 bits, holds count-1)
  - load buffer (32 bits)
- Reset (rst=0, asynchronous, any state):
  - state=IDLE, idx=0, buffer=0.
  - mem_req_o=0, mem_we_o=0, mem_a_o=0, mem_dout_o=0.
  - stall_req_o=0, rd_data_o=0, rd_addr_o=0, rd_enable_o=0 (outputs are forced 0 while rst is low).
  - A transfer in flight is abandoned; no partial result is ever emitted.
- IDLE, non-memory op: rd_*_o = rd_*_i combinationally; stall_req_o=0; zero added latency.
- IDLE, memory op:
  - stall_req_o=1 combinationally; rd_enable_o=0.
  - Next edge: ACCESS, idx=0, nbytes = 0/1/3 for B/H/W.
- ACCESS:
  - mem_req_o=1, mem_we_o = store, mem_a_o = mem_addr_i + idx (mod 2^ADDR_W, wraps silently).
  - mem_dout_o = byte idx of rd_data_i (little-endian).
  - stall_req_o=1, rd_enable_o=0.
  - Each rising edge with mem_ack_i=1: for loads, buffer byte idx <= mem_din_i. Then if idx==nbytes go to DONE, else idx+1.
  - mem_ack_i is ignored outside ACCESS.
  - An ack held high continuously (zero-wait controller) completes one byte per cycle.
- DONE (exactly one cycle, then IDLE):
  - mem_req_o=0, stall_req_o=0.
  - Load: rd_data_o = extended buffer (LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend), rd_addr_o = rd_addr_i, rd_enable_o = rd_enable_i.
  - Store: rd_enable_o=0.
  - mem_wb latches on this edge, and ex_mem advances on it.
- Inputs must stay stable from IDLE detection through DONE; ex_mem guarantees this via stall[4].
- Misaligned addresses are legal; bytes are accessed sequentially with no fault.
- A bubble (aluop=`NOP, rd_enable_i=0) in IDLE passes as zero-effect.
- Back-to-back memory ops: DONE→IDLE sees the next op, and stall reasserts that cycle.
- Cycle counts with ack tied high:
  - LW: stall_req_o high 5 cycles (1 IDLE + 4 ACCESS), then 1 DONE cycle; 6 cycles total.
  - LB/SB: 3 cycles total.

Test Plan:
- aluop=`ADD, rd_data_i=0x12345678, rd_addr_i=5, rd_enable_i=1 -> outputs mirror the inputs in the same cycle; stall_req_o=0; mem_req_o=0.
- `LW at 0x100, ack tied high, memory bytes 0x78,0x56,0x34,0x12 -> mem_a_o 0x100..0x103 on consecutive cycles; stall_req_o high 5 cycles; DONE rd_data_o=0x12345678 with rd_enable_o=1.
- `LB at 0x7, byte 0x80 -> rd_data_o=0xFFFFFF80. `LBU on the same byte -> rd_data_o=0x00000080. `LH of bytes 0x00,0x90 -> 0xFFFF9000.
- `SH at 0xFFFFFFFF with rd_data_i=0xAABBCCDD, ack delayed 2 cycles per byte -> writes 0xDD@0xFFFFFFFF then 0xCC@0x00000000; mem_we_o=1; rd_enable_o stays 0 throughout.
- rst driven low mid-`LW after 2 acks -> mem_req_o and stall_req_o drop immediately, state returns to IDLE; a `LW issued after reset re-reads from byte 0.
- `SW immediately followed by `LW to the same address, ack high -> the LW starts the cycle after the SW's DONE and returns the stored word.
